// File: rtl/uart_rx_buffer.sv
// Receive-side frame FIFO between the UART receiver and the APB bridge.
// Edge-detects rx_done, stores {error, data} first-word-fall-through, tracks sticky overrun.
module uart_rx_buffer #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ERR_W    = 3,
   parameter int unsigned AF_LEVEL = 12
) (
   input  logic                     aclk,
   input  logic                     areset_n,
   input  logic                     rx_done,
   input  logic [DATA_W-1:0]        rx_data,
   input  logic [ERR_W-1:0]         rx_error,
   input  logic                     rd_en,
   input  logic                     flush,
   input  logic                     clr_overrun,
   output logic [DATA_W-1:0]        rd_data,
   output logic [ERR_W-1:0]         rd_error,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overrun
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = DATA_W + ERR_W;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overrun_q, overrun_d;
   logic          rx_done_q;

   logic          push_c;
   logic          pop_ok_c;
   logic          push_ok_c;
   logic          drop_c;
   logic [EW-1:0] head_c;

   // Flags decode straight from the registered count so they never glitch.
   assign empty       = (count_q == '0);
   assign full        = (count_q == CW'(DEPTH));
   assign almost_full = (count_q >= CW'(AF_LEVEL));
   assign count       = count_q;
   assign overrun     = overrun_q;

   assign push_c    = rx_done & ~rx_done_q;
   assign pop_ok_c  = rd_en & ~empty;
   assign push_ok_c = push_c & (~full | pop_ok_c);
   assign drop_c    = push_c & full & ~pop_ok_c & ~flush;

   assign head_c   = mem_q[rd_ptr_q];
   assign rd_data  = empty ? '0 : head_c[DATA_W-1:0];
   assign rd_error = empty ? '0 : head_c[EW-1:DATA_W];

   // Pointer, occupancy and overrun next-state; flush overrides push/pop.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      if (drop_c)           overrun_d = 1'b1;
      else if (clr_overrun) overrun_d = 1'b0;
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         rx_done_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
         rx_done_q <= rx_done;
      end
   end

   // Storage is not reset; the empty gate hides stale entries.
   always_ff @(posedge aclk) begin
      if (push_ok_c && !flush) mem_q[wr_ptr_q] <= {rx_error, rx_data};
   end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: directed vector table, hand sequences and random
// traffic compared against a queue-based reference model.
module tb_uart_rx_buffer;

   localparam int DEPTH    = 16;
   localparam int DATA_W   = 8;
   localparam int ERR_W    = 3;
   localparam int AF_LEVEL = 12;

   logic              aclk = 1'b0;
   logic              areset_n;
   logic              rx_done;
   logic [DATA_W-1:0] rx_data;
   logic [ERR_W-1:0]  rx_error;
   logic              rd_en;
   logic              flush;
   logic              clr_overrun;
   logic [DATA_W-1:0] rd_data;
   logic [ERR_W-1:0]  rd_error;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic [$clog2(DEPTH):0] count;
   logic              overrun;

   uart_rx_buffer #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .ERR_W(ERR_W), .AF_LEVEL(AF_LEVEL)
   ) dut (
      .aclk(aclk), .areset_n(areset_n), .rx_done(rx_done), .rx_data(rx_data),
      .rx_error(rx_error), .rd_en(rd_en), .flush(flush), .clr_overrun(clr_overrun),
      .rd_data(rd_data), .rd_error(rd_error), .empty(empty), .full(full),
      .almost_full(almost_full), .count(count), .overrun(overrun)
   );

   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;

   // Reference model: a queue of {err, data} frames plus overrun and last rx_done.
   logic [ERR_W+DATA_W-1:0] mq[$];
   bit m_over;
   bit m_prev;

   typedef struct {
      logic       done;
      logic [7:0] data;
      logic [2:0] err;
      logic       rd;
      int         ecount;
      logic       eempty;
      logic [7:0] edata;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_over = 1'b0;
      m_prev = 1'b0;
   endtask

   task automatic model_step();
      bit push, drop;
      push = rx_done && !m_prev;
      m_prev = rx_done;
      drop = 1'b0;
      if (flush) begin
         mq.delete();
      end else begin
         if (rd_en && mq.size() > 0) void'(mq.pop_front());
         if (push) begin
            if (mq.size() < DEPTH) mq.push_back({rx_error, rx_data});
            else drop = 1'b1;
         end
      end
      if (drop) m_over = 1'b1;
      else if (clr_overrun) m_over = 1'b0;
   endtask

   task automatic check_model(input string tag);
      int n;
      logic [ERR_W+DATA_W-1:0] h;
      n = mq.size();
      h = (n > 0) ? mq[0] : '0;
      chk({tag, " count"},       32'(count),       32'(n));
      chk({tag, " empty"},       32'(empty),       32'(n == 0));
      chk({tag, " full"},        32'(full),        32'(n == DEPTH));
      chk({tag, " almost_full"}, 32'(almost_full), 32'(n >= AF_LEVEL));
      chk({tag, " overrun"},     32'(overrun),     32'(m_over));
      chk({tag, " rd_data"},     32'(rd_data),     32'(h[DATA_W-1:0]));
      chk({tag, " rd_error"},    32'(rd_error),    32'(h[ERR_W+DATA_W-1:DATA_W]));
   endtask

   task automatic cycle(input logic d, input logic [7:0] dat, input logic [2:0] e,
                        input logic r, input logic f, input logic c, input string tag);
      rx_done = d; rx_data = dat; rx_error = e;
      rd_en = r; flush = f; clr_overrun = c;
      model_step();
      @(posedge aclk); #1;
      check_model(tag);
   endtask

   task automatic idle(input string tag);
      cycle(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, tag);
   endtask

   task automatic push_byte(input logic [7:0] dat, input logic [2:0] e, input string tag);
      cycle(1'b1, dat, e, 1'b0, 1'b0, 1'b0, tag);
      idle(tag);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " count"},       32'(count),       32'd0);
      chk({tag, " empty"},       32'(empty),       32'd1);
      chk({tag, " full"},        32'(full),        32'd0);
      chk({tag, " almost_full"}, 32'(almost_full), 32'd0);
      chk({tag, " overrun"},     32'(overrun),     32'd0);
      chk({tag, " rd_data"},     32'(rd_data),     32'd0);
      chk({tag, " rd_error"},    32'(rd_error),    32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      areset_n = 1'b0; rx_done = 1'b0; rx_data = '0; rx_error = '0;
      rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
      model_reset();
      #12;
      check_reset_values("reset");
      @(posedge aclk); #1;
      areset_n = 1'b1;

      // Level-held rx_done pushes once; pop returns to empty.
      tbl[0] = '{1'b1, 8'h41, 3'b000, 1'b0, 1, 1'b0, 8'h41};
      tbl[1] = '{1'b1, 8'h41, 3'b000, 1'b0, 1, 1'b0, 8'h41};
      tbl[2] = '{1'b1, 8'h41, 3'b000, 1'b0, 1, 1'b0, 8'h41};
      tbl[3] = '{1'b1, 8'h41, 3'b000, 1'b0, 1, 1'b0, 8'h41};
      tbl[4] = '{1'b1, 8'h41, 3'b000, 1'b0, 1, 1'b0, 8'h41};
      tbl[5] = '{1'b0, 8'h00, 3'b000, 1'b1, 0, 1'b1, 8'h00};
      tbl[6] = '{1'b0, 8'h00, 3'b000, 1'b1, 0, 1'b1, 8'h00};
      for (int i = 0; i < 7; i++) begin
         cycle(tbl[i].done, tbl[i].data, tbl[i].err, tbl[i].rd, 1'b0, 1'b0, "tbl");
         chk($sformatf("tbl[%0d] count", i), 32'(count), 32'(tbl[i].ecount));
         chk($sformatf("tbl[%0d] empty", i), 32'(empty), 32'(tbl[i].eempty));
         chk($sformatf("tbl[%0d] rd_data", i), 32'(rd_data), 32'(tbl[i].edata));
      end

      // Fill 0x10..0x1F with an error flag on 0x15.
      for (int i = 0; i < 16; i++) begin
         push_byte(8'(8'h10 + i), (i == 5) ? 3'b010 : 3'b000, "fill");
         chk("fill af", 32'(almost_full), 32'((i + 1) >= AF_LEVEL));
      end
      chk("fill count16", 32'(count), 32'd16);
      chk("fill full", 32'(full), 32'd1);

      // Dropped push, then clear colliding with a second drop, then clear alone.
      cycle(1'b1, 8'h99, 3'b000, 1'b0, 1'b0, 1'b0, "drop");
      chk("drop overrun", 32'(overrun), 32'd1);
      chk("drop count", 32'(count), 32'd16);
      chk("drop head", 32'(rd_data), 32'h10);
      idle("drop");
      cycle(1'b1, 8'h98, 3'b000, 1'b0, 1'b0, 1'b1, "setwins");
      chk("setwins overrun", 32'(overrun), 32'd1);
      idle("setwins");
      cycle(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, "clr");
      chk("clr overrun", 32'(overrun), 32'd0);

      // Push with pop while full: both accepted.
      cycle(1'b1, 8'h77, 3'b000, 1'b1, 1'b0, 1'b0, "fullpp");
      chk("fullpp count", 32'(count), 32'd16);
      chk("fullpp overrun", 32'(overrun), 32'd0);
      idle("fullpp");
      for (int i = 0; i < 15; i++) begin
         chk("pop order", 32'(rd_data), 32'(8'h11 + i));
         chk("pop err", 32'(rd_error), (rd_data == 8'h15) ? 32'd2 : 32'd0);
         cycle(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, "drain");
      end
      chk("after15 head", 32'(rd_data), 32'h77);
      cycle(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, "drain");

      // Interleaved traffic with occupancy kept within 0..3 to exercise pointer wrap.
      for (int t = 0; t < 40; t++) begin
         bit p, r;
         r = 1'($urandom_range(0, 1));
         p = ($urandom_range(0, 3) != 0);
         if (mq.size() >= 3 && !r) p = 1'b0;
         cycle(p, 8'($urandom), 3'($urandom), r, 1'b0, 1'b0, "wrap");
         idle("wrap");
      end
      for (int i = 0; i < 4; i++)
         if (mq.size() > 0) cycle(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, "wrapdrain");
      cycle(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, "popempty");
      chk("popempty count", 32'(count), 32'd0);

      // Push together with pop on an empty FIFO.
      cycle(1'b1, 8'h3C, 3'b001, 1'b1, 1'b0, 1'b0, "emptypp");
      chk("emptypp count", 32'(count), 32'd1);
      chk("emptypp data", 32'(rd_data), 32'h3C);
      idle("emptypp");

      // Unconstrained random traffic.
      for (int t = 0; t < 400; t++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 15) == 0), "rand");
      end

      // Flush keeps overrun; flush beats a simultaneous push.
      cycle(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, "flush0");
      for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i), 3'b000, "refill");
      push_byte(8'hEE, 3'b000, "refill drop");
      chk("refill overrun", 32'(overrun), 32'd1);
      cycle(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, "flush1");
      for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i), 3'b000, "store5");
      chk("store5 count", 32'(count), 32'd5);
      cycle(1'b1, 8'hAA, 3'b000, 1'b0, 1'b1, 1'b0, "flushpush");
      chk("flushpush count", 32'(count), 32'd0);
      chk("flushpush empty", 32'(empty), 32'd1);
      chk("flushpush overrun", 32'(overrun), 32'd1);
      idle("flushpush");

      // Asynchronous reset mid-fill, with rx_done already high at release.
      push_byte(8'h01, 3'b000, "prefill");
      push_byte(8'h02, 3'b000, "prefill");
      #2;
      areset_n = 1'b0;
      #1;
      check_reset_values("midreset");
      model_reset();
      rx_done = 1'b1; rx_data = 8'h55; rx_error = 3'b000;
      @(posedge aclk); #1;
      areset_n = 1'b1;
      cycle(1'b1, 8'h55, 3'b000, 1'b0, 1'b0, 1'b0, "release");
      chk("release count", 32'(count), 32'd1);
      chk("release data", 32'(rd_data), 32'h55);
      cycle(1'b1, 8'h55, 3'b000, 1'b0, 1'b0, 1'b0, "releasehold");
      idle("releasehold");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
